// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store memory initiator: funct3 widths and FSM states.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLdRd,
        StStWr,
        StRmwRd,
        StRmwWr,
        StDone,
        StErr
    } state_e;

    // Stores only exist as B/H/W; loads additionally have the unsigned forms.
    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        logic bad;
        bad = 1'b1;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = write;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = (lo != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling: load extract-and-extend and store read-modify-write merge.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (lane[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the word-indexed unified memory.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 17001,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;

    logic [ADDR_W-1:0] req_word;
    logic              req_err;
    logic              accept;
    logic              capture_rdata;
    logic [31:0]       load_data;
    logic [31:0]       merged_word;

    assign req_word = req_addr >> 2;
    assign req_err  = f3_illegal(req_write, req_funct3)
                    | misaligned(req_funct3, req_addr[1:0])
                    | (req_word >= ADDR_W'(MEM_WORDS));
    assign accept   = (state_q == StIdle) && req_valid;

    mem_lane_align u_lane_align (
        .word       (data_q),
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            data_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (capture_rdata) begin
                data_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_err       = 1'b0;
        resp_rdata     = 32'd0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = 32'd0;
        capture_rdata  = 1'b0;
        // Address is parked at zero only while idle, stable for the whole transaction.
        mem_address    = (state_q == StIdle) ? '0 : (addr_q >> 2);

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StErr;
                    end else if (!req_write) begin
                        state_d = StLdRd;
                    end else if (req_funct3 == F3_W) begin
                        state_d = StStWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLdRd: begin
                mem_read      = 1'b1;
                capture_rdata = 1'b1;
                state_d       = StDone;
            end
            StStWr: begin
                mem_write      = 1'b1;
                mem_write_data = wdata_q;
                state_d        = StDone;
            end
            StRmwRd: begin
                mem_read      = 1'b1;
                capture_rdata = 1'b1;
                state_d       = StRmwWr;
            end
            StRmwWr: begin
                mem_write      = 1'b1;
                mem_write_data = merged_word;
                state_d        = StDone;
            end
            StDone: begin
                resp_valid = 1'b1;
                resp_rdata = write_q ? 32'd0 : load_data;
                state_d    = StIdle;
            end
            StErr: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

    localparam int unsigned MEM_WORDS = 17001;
    localparam int unsigned ADDR_W    = 32;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic        bk_we;
    logic [14:0] bk_addr;
    logic [31:0] bk_data;

    int errors;
    int checks;

    mem_access_unit #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Garbage pattern when not reading, so a stray capture shows up.
    assign mem_rdata = (mem_read && mem_address < MEM_WORDS) ? mem[mem_address[14:0]]
                                                             : 32'hBADC0DE5;

    always @(posedge clk) begin
        if (mem_write && mem_address < MEM_WORDS) begin
            mem[mem_address[14:0]] <= mem_write_data;
        end else if (bk_we) begin
            mem[bk_addr] <= bk_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        bk_we   = 1'b1;
        bk_addr = idx[14:0];
        bk_data = val;
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    // One request; reports latency (0 = timeout) and memory activity seen.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                          output int lat, output int rd_cnt, output int wr_cnt,
                          output logic [31:0] wr_addr, output int both_cnt);
        lat      = 0;
        rd_cnt   = 0;
        wr_cnt   = 0;
        both_cnt = 0;
        wr_addr  = 32'hFFFF_FFFF;
        rdata    = 32'hFFFF_FFFF;
        err      = 1'bx;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                wr_addr = mem_address;
            end
            if (mem_read && mem_write) both_cnt++;
            if (resp_valid) begin
                lat   = n;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        logic [31:0] rd, wa;
        logic        e;
        int          lat, rc, wc, bc;
        do_req(1'b0, f3, addr, 32'h0, rd, e, lat, rc, wc, wa, bc);
        check({tag, "_data"}, rd, exp);
        check({tag, "_lat"}, lat, 2);
        check({tag, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic err_chk(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr);
        logic [31:0] rd, wa;
        logic        e;
        int          lat, rc, wc, bc;
        do_req(wr, f3, addr, 32'h5A5A_5A5A, rd, e, lat, rc, wc, wa, bc);
        check({tag, "_err"}, {31'd0, e}, 32'd1);
        check({tag, "_lat"}, lat, 1);
        check({tag, "_rdata"}, rd, 32'd0);
        check({tag, "_memops"}, rc + wc, 0);
    endtask

    initial begin
        logic [31:0] rd, wa;
        logic        e;
        int          lat, rc, wc, bc;
        int          acc, busy, nresp;
        logic        acc_now;
        logic [31:0] resp_d [0:1];

        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        bk_we      = 1'b0;
        bk_addr    = 15'd0;
        bk_data    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(5, 32'h80FF7F01);
        preload(16960, 32'hCAFEF00D);
        preload(17000, 32'h0BADF00D);

        load_chk("lb16", 3'b000, 32'h16, 32'hFFFFFFFF);
        load_chk("lbu17", 3'b100, 32'h17, 32'h00000080);
        load_chk("lh14", 3'b001, 32'h14, 32'h00007F01);
        load_chk("lhu16", 3'b101, 32'h16, 32'h000080FF);
        load_chk("lh16", 3'b001, 32'h16, 32'hFFFF80FF);
        load_chk("lb15", 3'b000, 32'h15, 32'h0000007F);
        load_chk("lw14", 3'b010, 32'h14, 32'h80FF7F01);

        do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, rd, e, lat, rc, wc, wa, bc);
        check("sw_lat", lat, 2);
        check("sw_rdata", rd, 32'd0);
        check("sw_wr_cnt", wc, 1);
        check("sw_rd_cnt", rc, 0);
        check("sw_wr_addr", wa, 32'd8);
        check("sw_mem8", mem[8], 32'hDEADBEEF);
        load_chk("lw20", 3'b010, 32'h20, 32'hDEADBEEF);

        do_req(1'b1, 3'b000, 32'h21, 32'h000000AA, rd, e, lat, rc, wc, wa, bc);
        check("sb_lat", lat, 3);
        check("sb_ops", {rc[15:0], wc[15:0]}, {16'd1, 16'd1});
        check("sb_both", bc, 0);
        check("sb_mem8", mem[8], 32'hDEADAAEF);
        do_req(1'b1, 3'b001, 32'h22, 32'h00001234, rd, e, lat, rc, wc, wa, bc);
        check("sh_lat", lat, 3);
        check("sh_mem8", mem[8], 32'h1234AAEF);

        err_chk("lw_mis", 1'b0, 3'b010, 32'h22);
        err_chk("sh_mis", 1'b1, 3'b001, 32'h23);
        err_chk("f3_011", 1'b0, 3'b011, 32'h10);
        err_chk("f3_110", 1'b0, 3'b110, 32'h10);
        err_chk("st_bu", 1'b1, 3'b100, 32'h10);
        err_chk("oor_10a04", 1'b0, 3'b010, 32'h10A04);
        err_chk("oor_17001", 1'b0, 3'b010, 32'h109A4);
        load_chk("lw_16960", 3'b010, 32'h10900, 32'hCAFEF00D);
        load_chk("lw_17000", 3'b010, 32'h109A0, 32'h0BADF00D);

        // Reset asserted while the RMW write strobe is up must suppress the write.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rd_phase", {30'd0, mem_read, mem_write}, 32'd2);
        @(negedge clk);
        check("rmw_wr_phase", {30'd0, mem_read, mem_write}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mid_addr", mem_address, 32'd0);
        check("rst_mid_wdata", mem_write_data, 32'd0);
        check("rst_mid_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_mem8", mem[8], 32'h1234AAEF);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);

        // Back-to-back LW then SW with req_valid held high throughout.
        acc   = 0;
        busy  = 0;
        nresp = 0;
        resp_d[0] = 32'hFFFF_FFFF;
        resp_d[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        req_wdata  = 32'h0;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid && nresp < 2) begin
                resp_d[nresp] = resp_rdata;
                nresp++;
            end else if (resp_valid) begin
                nresp++;
            end
            acc_now = req_valid && req_ready;
            if (req_valid && !req_ready) busy++;
            @(posedge clk);
            #1;
            if (acc_now) begin
                acc++;
                if (acc == 1) begin
                    req_write  = 1'b1;
                    req_addr   = 32'h24;
                    req_wdata  = 32'h11223344;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc, 2);
        check("b2b_busy", busy, 2);
        check("b2b_resps", nresp, 2);
        check("b2b_resp0", resp_d[0], 32'h80FF7F01);
        check("b2b_resp1", resp_d[1], 32'd0);
        check("b2b_mem9", mem[9], 32'h11223344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator for the unified word-indexed instruction/data memory of the multicycle RV32I core.
- Accepts one byte-addressed load/store request at a time from the datapath/control FSM, and drives the memory's word address, write data, read strobe and write strobe.
- Loads: extracts and sign/zero-extends bytes and halfwords from the word read back.
- SB/SH: performs read-modify-write on the whole word.
- Checks alignment and range before touching memory.

Parameters:
MEM_WORDS, 17001, number of 32-bit words in the memory; legal word index 0..MEM_WORDS-1
ADDR_W, 32, width of byte address and memory word-address port

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present; accepted when req_valid && req_ready
req_ready  out  1  high only in IDLE
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2), low bits used for B/H
resp_valid  out  1  one-cycle pulse, request complete
resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores/errors
resp_err  out  1  with resp_valid: misaligned, out of range, or illegal funct3
mem_address  out  ADDR_W  word index = captured req_addr >> 2
mem_write_data  out  32  word to write
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe, sampled by memory on rising clk
mem_rdata  in  32  memory read data, combinational from mem_address while mem_read=1, undefined otherwise

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all request capture registers = 0; resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0. mem_read/mem_write are decoded from the state register, so they fall immediately on reset assertion; a write in progress is aborted with no write.
- Acceptance: in IDLE, req_valid=1 registers write, funct3, addr, wdata and computes err.
- err = any of:
  - H/HU with addr[0] != 0
  - W with addr[1:0] != 0
  - funct3 in {011, 110, 111}
  - 011 for stores, any of {100, 101} for stores
  - (addr >> 2) >= MEM_WORDS
- States:
  - IDLE: req_ready=1. Accept → ERR if err; else LD_RD for loads; ST_WR for SW; RMW_RD for SB/SH.
  - LD_RD: mem_read=1. Capture mem_rdata into the data register at end of cycle → DONE.
  - ST_WR: mem_write=1, mem_write_data=wdata → DONE.
  - RMW_RD: mem_read=1. Capture the old word → RMW_WR.
  - RMW_WR: mem_write=1. mem_write_data = old word with byte lane addr[1:0] (SB) or halfword lane addr[1] (SH) replaced by wdata[7:0] / wdata[15:0] → DONE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0 → IDLE. No mem_read/mem_write is ever asserted.
  - DONE: resp_valid=1, resp_err=0, resp_rdata=extracted data (loads) or 0 (stores) → IDLE.
- Latency, counted from the accept edge:
  - LW/LB/LH/LBU/LHU and SW: response in the 2nd cycle after accept.
  - SB/SH: response in the 3rd cycle.
  - Error: response in the 1st cycle.
- Throughput: back-to-back requests are possible. A new request may be accepted in the cycle after DONE/ERR.
- Extraction:
  - Byte lane k = addr[1:0] selects bits [8k+7:8k].
  - Halfword lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- mem_address is held stable throughout a transaction (0 when IDLE). mem_write_data is 0 outside write states.
- req_* inputs are ignored outside IDLE; no input changes affect an in-flight operation.
- Never asserts mem_read and mem_write in the same cycle.

Decomposition:
- Shared package holds:
  - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (IDLE, LD_RD, ST_WR, RMW_RD, RMW_WR, DONE, ERR)
- One natural combinational sub-module: mem_lane_align. It contains the byte/halfword extract-and-extend (load path) and the lane merge (store path). It is shared by LD_RD/DONE and RMW_WR.

Test Plan:
- Memory word 5 = 0x80FF7F01; LB addr 0x16 → resp_rdata 0xFFFFFF7F? No: lane 2 = 0xFF → 0xFFFFFFFF; LBU addr 0x17 → 0x00000080; LH addr 0x14 → 0x00007F01; LHU addr 0x16 → 0x000080FF. Each response arrives 2 cycles after accept.
- SW addr 0x20 wdata 0xDEADBEEF → one cycle with mem_write=1, mem_address=8; word 8 reads back 0xDEADBEEF via LW.
- Word 8 = 0xDEADBEEF; SB addr 0x21 wdata 0x000000AA → RMW_RD then RMW_WR, word 8 = 0xDEADAAEF, resp 3 cycles after accept; SH addr 0x22 wdata 0x1234 → 0x1234AAEF.
- LW addr 0x22, SH addr 0x23, funct3 011, addr 0x10900 (word 16960 ok) vs 0x10A04 (word 17025 ≥ 17001) → misaligned/illegal/out-of-range cases give resp_err=1 one cycle after accept with zero mem_read/mem_write activity; the in-range case succeeds.
- Assert rst_n=0 during RMW_WR of an SB → mem_write drops immediately; target word unchanged; state IDLE; all outputs 0; req_ready=1 after release.
- Issue LW then SW back-to-back with req_valid held high → req_ready low while busy, each request accepted exactly once, two resp_valid pulses, correct order.
